// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states and op decode helpers.
package muldiv_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_div_core.sv
// Restoring radix-2 divider datapath: one quotient bit per step on operand magnitudes,
// with sign correction and divide-by-zero override applied to the final step's outputs.
module muldiv_iter_div_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_fix;

  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];

  // Magnitudes are taken as unsigned, so the most negative value maps to 2^(WIDTH-1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_start) begin
      r_quo   <= w_a_neg ? (~i_a + 1'b1) : i_a;
      r_dvs   <= w_b_neg ? (~i_b + 1'b1) : i_b;
      r_rem   <= '0;
      r_a     <= i_a;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_b == '0);
    end else if (i_step) begin
      r_quo <= w_quo_nx;
      r_rem <= w_rem_nx;
    end
  end

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_fits    = ~w_diff[WIDTH];
  assign w_rem_nx  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx  = {r_quo[WIDTH-2:0], w_fits};
  assign w_quo_fix = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_rem_fix = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

  // Valid on the last step; the top latches it when leaving the DIV state.
  assign o_result = r_dz ? {r_a, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage: valid/ready op intake, held {hi,lo}
// result with ack, busy line for stall logic, and flush cancel.
//
// state   | meaning
// IDLE    | ready for a new op (ready_o=1)
// MUL     | product settling for MUL_LAT cycles (busy_o=1)
// DIV     | one quotient bit per cycle for WIDTH cycles (busy_o=1)
// DONE    | result held until out_ack_i (done_o=1)
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               out_ack_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul_signed;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_start_div;
  logic               w_step_div;
  logic [2*WIDTH-1:0] w_ma;
  logic [2*WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_div_result;

  assign w_accept    = valid_i & r_ready & ~flush;
  assign w_start_div = w_accept & op_is_div(op_i);
  assign w_step_div  = (r_state == ST_DIV) & ~flush;

  // Low 2*WIDTH bits of the extended product are exact for both signed and unsigned.
  assign w_ma   = {{WIDTH{r_mul_signed & r_a[WIDTH-1]}}, r_a};
  assign w_mb   = {{WIDTH{r_mul_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ma * w_mb;

  muldiv_iter_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start_div),
    .i_step   (w_step_div),
    .i_signed (op_is_signed(op_i)),
    .i_a      (a_i),
    .i_b      (b_i),
    .o_result (w_div_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mul_signed <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_mul_signed <= op_is_signed(op_i);
            r_a          <= a_i;
            r_b          <= b_i;
            r_ready      <= 1'b0;
            r_busy       <= 1'b1;
            if (op_is_div(op_i)) begin
              r_state <= ST_DIV;
              r_cnt   <= CNT_W'(WIDTH - 1);
            end else begin
              r_state <= ST_MUL;
              r_cnt   <= CNT_W'(MUL_LAT - 1);
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_result <= w_prod;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (r_cnt == '0) begin
            r_state  <= ST_DONE;
            r_result <= w_div_result;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ack_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: timing/result model compared every cycle,
// directed corner ops with literal expectations, then randomized ops with flushes.
module tb_muldiv_iter;

  localparam int W  = 32;
  localparam int ML = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           valid_i;
  logic           ready_o;
  logic [1:0]     op_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           done_o;
  logic           out_ack_i;
  logic [2*W-1:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(
    .WIDTH   (W),
    .MUL_LAT (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .out_ack_i (out_ack_i),
    .result_o  (result_o)
  );

  // Reference arithmetic: plain 64-bit math, truncating signed division.
  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Timing model: 0 = idle, 1 = working, 2 = holding result.
  int          m_phase  = 0;
  int          m_remain = 0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_result  = '0;
  bit          chk_en    = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase  = 0;
      m_remain = 0;
      m_result = '0;
    end else if (flush) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (valid_i) begin
          m_pending = ref_calc(op_i, a_i, b_i);
          m_remain  = op_i[1] ? W : ML;
          m_phase   = 1;
        end
        1: begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase  = 2;
            m_result = m_pending;
          end
        end
        default: if (out_ack_i) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("ready_o", ready_o, m_phase == 0);
      check_bit("busy_o", busy_o, m_phase == 1);
      check_bit("done_o", done_o, m_phase == 2);
      check64("result_o", result_o, m_result);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int flush_at, output logic [63:0] res,
                        output int lat, output int bc, output bit fl);
    int guard;
    guard = 0;
    fl  = 1'b0;
    res = '0;
    lat = 0;
    bc  = 0;
    while (!ready_o && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_wait: ready_o=%b required 1 within 100 cycles", ready_o);
      return;
    end
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i    = 2'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    lat = 1;
    bc  = int'(busy_o);
    while (!done_o && lat < 100) begin
      if (lat == flush_at) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fl = 1'b1;
        check_bit("flush_ready", ready_o, 1'b1);
        check_bit("flush_done", done_o, 1'b0);
        return;
      end
      @(posedge clk); #1;
      lat++;
      bc += int'(busy_o);
    end
    if (!done_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_wait: done_o=%b required 1 within 100 cycles", done_o);
      return;
    end
    res = result_o;
    // A request while holding must be ignored.
    valid_i = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    valid_i   = 1'b0;
    out_ack_i = 1'b1;
    @(posedge clk); #1;
    out_ack_i = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    int          lat, bc;
    bit          fl;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          fat;

    rst = 1'b0; flush = 1'b0; valid_i = 1'b0; out_ack_i = 1'b0;
    op_i = 2'd0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_bit("rst_ready", ready_o, 1'b1);
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_done", done_o, 1'b0);
    check64("rst_result", result_o, 64'h0);
    rst = 1'b1;

    check64("pin_div_neg", ref_calc(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check64("pin_div_ovf", ref_calc(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check64("pin_multu", ref_calc(2'd1, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);

    run_op(2'd3, 32'd100, 32'd7, 0, -1, res, lat, bc, fl);
    check64("divu_100_7", res, 64'h0000_0002_0000_000E);
    check_int("divu_latency", lat, 33);
    check_int("divu_busy_cycles", bc, 32);

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, -1, res, lat, bc, fl);
    check64("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, -1, res, lat, bc, fl);
    check64("div_7_m2", res, 64'h0000_0001_FFFF_FFFD);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, res, lat, bc, fl);
    check64("div_overflow", res, 64'h0000_0000_8000_0000);
    run_op(2'd3, 32'd5, 32'd0, 0, -1, res, lat, bc, fl);
    check64("divu_by_zero", res, 64'h0000_0005_FFFF_FFFF);
    check_int("div0_latency", lat, 33);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, -1, res, lat, bc, fl);
    check64("div_by_zero", res, 64'hFFFF_FFF0_FFFF_FFFF);

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 0, -1, res, lat, bc, fl);
    check64("mult_m1_2", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 5, -1, res, lat, bc, fl);
    check64("multu_ff_2", res, 64'h0000_0001_FFFF_FFFE);
    check_int("mul_latency", lat, 3);
    check64("retain_after_ack", result_o, 64'h0000_0001_FFFF_FFFE);

    run_op(2'd2, 32'd1000, 32'd3, 0, 10, res, lat, bc, fl);
    check_bit("flush_taken", fl, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    run_op(2'd1, 32'd3, 32'd4, 0, -1, res, lat, bc, fl);
    check64("multu_3_4", res, 64'd12);

    // Flush on the same edge as a request: nothing accepted.
    valid_i = 1'b1; flush = 1'b1; op_i = 2'd2; a_i = 32'd9; b_i = 32'd2;
    @(posedge clk); #1;
    valid_i = 1'b0; flush = 1'b0;
    check_bit("flush_accept_busy", busy_o, 1'b0);
    check_bit("flush_accept_ready", ready_o, 1'b1);

    // Reset in the middle of a divide.
    valid_i = 1'b1; op_i = 2'd3; a_i = 32'd50; b_i = 32'd3;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check64("midop_rst_result", result_o, 64'h0);
    check_bit("midop_rst_busy", busy_o, 1'b0);
    check_bit("midop_rst_ready", ready_o, 1'b1);
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = pick_operand();
      rb  = pick_operand();
      fat = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, rop[1] ? W : ML)) : -1;
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), fat, res, lat, bc, fl);
      if (!fl) begin
        check64("random_result", res, ref_calc(rop, ra, rb));
        check_int("random_latency", lat, rop[1] ? W + 1 : ML + 1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
